// File: rtl/cu_pkg.sv
// Shared control-unit definitions: control-word field positions, top-level sequencer
// encodings and the fetch control word. Used by cu_sequencer and the opcode decoders.
package cu_pkg;

    localparam int CW_WIDTH = 33;

    localparam int CW_ALU_DB_EN   = 32;
    localparam int CW_ALU_B_SEL   = 31;
    localparam int CW_ALU_FS_HI   = 30;
    localparam int CW_ALU_FS_LO   = 26;
    localparam int CW_RF_B_DB_EN  = 25;
    localparam int CW_SA_HI       = 24;
    localparam int CW_SA_LO       = 20;
    localparam int CW_SB_HI       = 19;
    localparam int CW_SB_LO       = 15;
    localparam int CW_DA_HI       = 14;
    localparam int CW_DA_LO       = 10;
    localparam int CW_RF_WRITE    = 9;
    localparam int CW_RAM_DB_EN   = 8;
    localparam int CW_RAM_WRITE   = 7;
    localparam int CW_PC_DB_EN    = 6;
    localparam int CW_PC_FS_HI    = 5;
    localparam int CW_PC_FS_LO    = 4;
    localparam int CW_PC_IN_SEL   = 3;
    localparam int CW_STATUS_LOAD = 2;
    localparam int CW_NS_HI       = 1;
    localparam int CW_NS_LO       = 0;

    localparam logic [1:0] PC_FS_INC = 2'b01;

    // Fetch cycle only asks the PC to increment; every other field stays idle.
    localparam logic [CW_WIDTH-1:0] CW_IDLE  = '0;
    localparam logic [CW_WIDTH-1:0] CW_FETCH = CW_WIDTH'(PC_FS_INC) << CW_PC_FS_LO;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        HALT  = 2'b10
    } cu_state_t;

endpackage

// File: rtl/cu_status_reg.sv
// 5-bit ALU status register with load enable and synchronous active-high reset.
module cu_status_reg (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [4:0] status_in,
    output logic [4:0] status_out
);

    logic [4:0] status_d;
    logic [4:0] status_q;

    always_comb begin
        status_d = status_q;
        if (load) begin
            status_d = status_in;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            status_q <= '0;
        end else begin
            status_q <= status_d;
        end
    end

    assign status_out = status_q;

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit sequencer: FETCH/EXEC/HALT machine, instruction register and execute sub-state.
// Optional EXEC watchdog enabled by defining CU_SEQUENCER_WATCHDOG_EN (adds port wdt_fault).
module cu_sequencer
    import cu_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [31:0]         instruction_in,
    input  logic                mem_ready,
    input  logic [CW_WIDTH-1:0] decoder_controlword,
    input  logic [4:0]          status_in,
    input  logic                halt_req,
    output logic [31:0]         instruction,
    output logic [1:0]          state,
    output logic [4:0]          status,
    output logic [CW_WIDTH-1:0] controlword,
    output logic                fetch_req,
    output logic                halted
`ifdef CU_SEQUENCER_WATCHDOG_EN
    ,
    output logic                wdt_fault
`endif
);

    cu_state_t   top_q, top_d;
    logic [31:0] ir_q, ir_d;
    logic [1:0]  sub_state_q, sub_state_d;
    logic        status_load;
    logic [1:0]  next_sub;

`ifdef CU_SEQUENCER_WATCHDOG_EN
    logic [3:0]  wdt_cnt_q, wdt_cnt_d;
    logic        wdt_fault_q, wdt_fault_d;
`endif

    assign next_sub = decoder_controlword[CW_NS_HI:CW_NS_LO];

    always_comb begin
        top_d       = top_q;
        ir_d        = ir_q;
        sub_state_d = sub_state_q;
        controlword = CW_IDLE;
        fetch_req   = 1'b0;
        halted      = 1'b0;
        status_load = 1'b0;
`ifdef CU_SEQUENCER_WATCHDOG_EN
        wdt_cnt_d   = wdt_cnt_q;
        wdt_fault_d = 1'b0;
`endif
        case (top_q)
            FETCH: begin
                fetch_req = 1'b1;
                // A pending halt wins over a ready instruction so the PC is left untouched.
                if (halt_req) begin
                    top_d = HALT;
                end else if (mem_ready) begin
                    controlword = CW_FETCH;
                    ir_d        = instruction_in;
                    sub_state_d = 2'b00;
                    top_d       = EXEC;
`ifdef CU_SEQUENCER_WATCHDOG_EN
                    wdt_cnt_d   = '0;
`endif
                end
            end
            EXEC: begin
                controlword = decoder_controlword;
                status_load = decoder_controlword[CW_STATUS_LOAD];
                if (next_sub == 2'b00) begin
                    top_d       = FETCH;
                    sub_state_d = 2'b00;
                end else begin
                    sub_state_d = next_sub;
                end
`ifdef CU_SEQUENCER_WATCHDOG_EN
                // The 16th consecutive EXEC cycle aborts the instruction.
                if (wdt_cnt_q == 4'd15) begin
                    top_d       = FETCH;
                    sub_state_d = 2'b00;
                    wdt_fault_d = 1'b1;
                end else begin
                    wdt_cnt_d = wdt_cnt_q + 4'd1;
                end
`endif
            end
            HALT: begin
                halted = 1'b1;
                if (!halt_req) begin
                    top_d = FETCH;
                end
            end
            default: begin
                top_d = FETCH;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            top_q       <= FETCH;
            ir_q        <= '0;
            sub_state_q <= 2'b00;
`ifdef CU_SEQUENCER_WATCHDOG_EN
            wdt_cnt_q   <= '0;
            wdt_fault_q <= 1'b0;
`endif
        end else begin
            top_q       <= top_d;
            ir_q        <= ir_d;
            sub_state_q <= sub_state_d;
`ifdef CU_SEQUENCER_WATCHDOG_EN
            wdt_cnt_q   <= wdt_cnt_d;
            wdt_fault_q <= wdt_fault_d;
`endif
        end
    end

    cu_status_reg u_status_reg (
        .clock      (clock),
        .reset      (reset),
        .load       (status_load),
        .status_in  (status_in),
        .status_out (status)
    );

    assign instruction = ir_q;
    assign state       = sub_state_q;
`ifdef CU_SEQUENCER_WATCHDOG_EN
    assign wdt_fault   = wdt_fault_q;
`endif

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: cycle-level behavioural model plus directed scenarios.
// Watchdog scenario is compiled in when CU_SEQUENCER_WATCHDOG_EN is defined.
module tb_cu_sequencer;

    localparam int M_FETCH = 0;
    localparam int M_EXEC  = 1;
    localparam int M_HALT  = 2;

    logic        clock;
    logic        reset;
    logic [31:0] instruction_in;
    logic        mem_ready;
    logic [32:0] decoder_controlword;
    logic [4:0]  status_in;
    logic        halt_req;
    logic [31:0] instruction;
    logic [1:0]  state;
    logic [4:0]  status;
    logic [32:0] controlword;
    logic        fetch_req;
    logic        halted;
`ifdef CU_SEQUENCER_WATCHDOG_EN
    logic        wdt_fault;
`endif

    int checks = 0;
    int failures = 0;

    // Behavioural model state, advanced once per rising edge.
    int          m_mode;
    logic [31:0] m_ir;
    logic [1:0]  m_state;
    logic [4:0]  m_status;
    int          m_exec_len;
    logic        m_wdt;
    bit          model_valid = 0;

    cu_sequencer dut (
        .clock               (clock),
        .reset               (reset),
        .instruction_in      (instruction_in),
        .mem_ready           (mem_ready),
        .decoder_controlword (decoder_controlword),
        .status_in           (status_in),
        .halt_req            (halt_req),
        .instruction         (instruction),
        .state               (state),
        .status              (status),
        .controlword         (controlword),
        .fetch_req           (fetch_req),
        .halted              (halted)
`ifdef CU_SEQUENCER_WATCHDOG_EN
        ,
        .wdt_fault           (wdt_fault)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle's inputs just after the rising edge, then return at the falling edge.
    task automatic applyStimulus(input logic r, input logic mr, input logic [31:0] ins,
                                 input logic [32:0] dcw, input logic [4:0] st, input logic hr);
        @(posedge clock);
        #1;
        reset               = r;
        mem_ready           = mr;
        instruction_in      = ins;
        decoder_controlword = dcw;
        status_in           = st;
        halt_req            = hr;
        @(negedge clock);
    endtask

    always @(posedge clock) begin
        m_wdt = 1'b0;
        if (reset) begin
            m_mode      = M_FETCH;
            m_ir        = '0;
            m_state     = 2'b00;
            m_status    = '0;
            m_exec_len  = 0;
            model_valid = 1;
        end else if (model_valid) begin
            if (m_mode == M_FETCH) begin
                if (halt_req) begin
                    m_mode = M_HALT;
                end else if (mem_ready) begin
                    m_ir       = instruction_in;
                    m_state    = 2'b00;
                    m_mode     = M_EXEC;
                    m_exec_len = 0;
                end
            end else if (m_mode == M_EXEC) begin
                if (decoder_controlword[2]) m_status = status_in;
                m_exec_len++;
                if (decoder_controlword[1:0] == 2'b00) begin
                    m_mode  = M_FETCH;
                    m_state = 2'b00;
                end else begin
                    m_state = decoder_controlword[1:0];
                end
`ifdef CU_SEQUENCER_WATCHDOG_EN
                if (m_exec_len == 16) begin
                    m_mode  = M_FETCH;
                    m_state = 2'b00;
                    m_wdt   = 1'b1;
                end
`endif
            end else begin
                if (!halt_req) m_mode = M_FETCH;
            end
        end
    end

    always @(negedge clock) begin
        logic [32:0] exp_cw;
        logic        exp_fr;
        logic        exp_h;
        if (model_valid) begin
            exp_cw = '0;
            exp_fr = 1'b0;
            exp_h  = 1'b0;
            if (m_mode == M_FETCH) begin
                exp_fr = 1'b1;
                if (mem_ready && !halt_req) exp_cw = 33'h10;
            end else if (m_mode == M_EXEC) begin
                exp_cw = decoder_controlword;
            end else begin
                exp_h = 1'b1;
            end
            checkOutput("model.controlword", 64'(controlword), 64'(exp_cw));
            checkOutput("model.fetch_req", 64'(fetch_req), 64'(exp_fr));
            checkOutput("model.halted", 64'(halted), 64'(exp_h));
            checkOutput("model.instruction", 64'(instruction), 64'(m_ir));
            checkOutput("model.state", 64'(state), 64'(m_state));
            checkOutput("model.status", 64'(status), 64'(m_status));
`ifdef CU_SEQUENCER_WATCHDOG_EN
            checkOutput("model.wdt_fault", 64'(wdt_fault), 64'(m_wdt));
`endif
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset               = 1'b1;
        mem_ready           = 1'b0;
        instruction_in      = '0;
        decoder_controlword = '0;
        status_in           = '0;
        halt_req            = 1'b0;

        applyStimulus(1, 0, 32'h0, 33'h0, 5'h0, 0);
        applyStimulus(1, 0, 32'h0, 33'h0, 5'h0, 0);

        // First cycle after reset.
        applyStimulus(0, 0, 32'h0, 33'h0, 5'h0, 0);
        checkOutput("reset.controlword", 64'(controlword), 64'h0);
        checkOutput("reset.fetch_req", 64'(fetch_req), 64'h1);
        checkOutput("reset.instruction", 64'(instruction), 64'h0);
        checkOutput("reset.state", 64'(state), 64'h0);
        checkOutput("reset.status", 64'(status), 64'h0);

        // Fetch 0x14000003 and walk sub-states 00 -> 01 -> 10 -> FETCH.
        applyStimulus(0, 1, 32'h1400_0003, 33'h0, 5'h0, 0);
        checkOutput("fetch.pc_inc", 64'(controlword), 64'h10);
        applyStimulus(0, 0, 32'h0, 33'h1_0000_0001, 5'h0, 0);
        checkOutput("exec0.ir", 64'(instruction), 64'h1400_0003);
        checkOutput("exec0.state", 64'(state), 64'h0);
        checkOutput("exec0.fetch_req", 64'(fetch_req), 64'h0);
        checkOutput("exec0.controlword", 64'(controlword), 64'h1_0000_0001);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0206, 5'b10101, 0);
        checkOutput("exec1.state", 64'(state), 64'h1);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'b00000, 0);
        checkOutput("exec2.state", 64'(state), 64'h2);
        checkOutput("exec2.status_loaded", 64'(status), 64'h15);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'b00000, 0);
        checkOutput("back_fetch.fetch_req", 64'(fetch_req), 64'h1);
        checkOutput("back_fetch.status_hold", 64'(status), 64'h15);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'b00000, 0);
        checkOutput("fetch_wait.fetch_req", 64'(fetch_req), 64'h1);

        // Halt requested mid-instruction: instruction completes, then HALT.
        applyStimulus(0, 1, 32'hA5A5_0001, 33'h0, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0001, 5'h0, 1);
        checkOutput("halt_exec0.halted", 64'(halted), 64'h0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0000, 5'h0, 1);
        checkOutput("halt_exec1.state", 64'(state), 64'h1);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 33'h0, 5'h0, 1);
        checkOutput("halt_fetch.controlword", 64'(controlword), 64'h0);
        applyStimulus(0, 1, 32'hDEAD_BEEF, 33'h0, 5'h0, 1);
        checkOutput("halt.halted", 64'(halted), 64'h1);
        checkOutput("halt.fetch_req", 64'(fetch_req), 64'h0);
        checkOutput("halt.ir_kept", 64'(instruction), 64'hA5A5_0001);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'h0, 0);
        checkOutput("unhalt.halted", 64'(halted), 64'h0);
        checkOutput("unhalt.fetch_req", 64'(fetch_req), 64'h1);

        // Reset while in EXEC sub-state 10.
        applyStimulus(0, 1, 32'h1234_5678, 33'h0, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0005, 5'b01010, 0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0002, 5'h0, 0);
        checkOutput("pre_reset.state", 64'(state), 64'h1);
        checkOutput("pre_reset.status", 64'(status), 64'h0A);
        applyStimulus(1, 0, 32'h0, 33'h0_0000_0001, 5'h1F, 0);
        checkOutput("in_reset.state", 64'(state), 64'h2);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'h0, 0);
        checkOutput("mid_reset.state", 64'(state), 64'h0);
        checkOutput("mid_reset.ir", 64'(instruction), 64'h0);
        checkOutput("mid_reset.status", 64'(status), 64'h0);
        checkOutput("mid_reset.fetch_req", 64'(fetch_req), 64'h1);

        // Sub-state repeating itself (next_state equal to current) is legal.
        applyStimulus(0, 1, 32'h0000_00FF, 33'h0, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0003, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0003, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0_0000_0000, 5'h0, 0);
        checkOutput("repeat.state", 64'(state), 64'h3);

        // Long EXEC: watchdog aborts at 16 cycles, otherwise EXEC continues.
        applyStimulus(0, 0, 32'h0, 33'h0, 5'h0, 0);
        applyStimulus(0, 1, 32'h0BAD_0BAD, 33'h0, 5'h0, 0);
        begin
            int exec_cycles;
            int fault_cycles;
            bit back;
            exec_cycles  = 0;
            fault_cycles = 0;
            back         = 0;
            for (int k = 0; k < 20; k++) begin
                applyStimulus(0, 0, 32'h0, 33'h0_0000_0001, 5'h0, 0);
                if (fetch_req) back = 1;
                if (!back) exec_cycles++;
`ifdef CU_SEQUENCER_WATCHDOG_EN
                if (wdt_fault) fault_cycles++;
`endif
            end
`ifdef CU_SEQUENCER_WATCHDOG_EN
            checkOutput("wdt.exec_cycles", 64'(exec_cycles), 64'd16);
            checkOutput("wdt.fault_pulses", 64'(fault_cycles), 64'd1);
`else
            checkOutput("nowdt.exec_cycles", 64'(exec_cycles), 64'd20);
            checkOutput("nowdt.fault_pulses", 64'(fault_cycles), 64'd0);
`endif
        end

        applyStimulus(1, 0, 32'h0, 33'h0, 5'h0, 0);
        applyStimulus(0, 0, 32'h0, 33'h0, 5'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
